bias_seq_ctrl: RTL and testbench
================================

Name: bias_seq_ctrl

Overview:
- Sequencer that replaces the generated bias streamer in front of a per-layer bias ROM.
- On a start pulse it reads bias[0..NUM_KERN-1] from the ROM in order and repeats that sweep PIX_PER_FRAME times.
- Each word is pushed into the downstream conv/accumulate FIFO using the ap_fifo write/full_n handshake.
- Sustains 1 word/cycle under no backpressure and never drops or duplicates a word under backpressure.

Parameters:
- NUM_KERN, 16, number of output kernels = bias ROM depth (>=1)
- DATA_WIDTH, 16, bias coefficient width (coeff_width)
- PIX_PER_FRAME, 64, output pixels per frame = number of bias sweeps (>=1)
- ADDR_W, max(1,$clog2(NUM_KERN)), ROM address width

Ports:
- ap_clk  in  1  clock; all logic rising-edge
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle frame start request
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last word is accepted
- bias_V_address0  out  ADDR_W  ROM read address
- bias_V_ce0  out  1  ROM read enable
- bias_V_q0  in  DATA_WIDTH  ROM data, valid the cycle after ce0
- output_V_din  out  DATA_WIDTH  FIFO write data
- output_V_full_n  in  1  FIFO not full
- output_V_write  out  1  FIFO write strobe

Behaviour:
- Interface: one clock ap_clk; reset ap_rst_n asynchronous, active-low. All registers clear immediately on assert; release is synchronous to ap_clk.
- Reset values: busy=0, done=0, ce0=0, address0=0, write=0, din=0, all counters and buffer 0.
- ROM timing: fixed 1-cycle read latency. A read issued in cycle t (ce0=1) returns q0 in t+1. q0 is captured unconditionally in t+1 into a 2-entry output buffer.
- Credit rule: issue a read only if (buffer occupancy + reads in flight) < 2. In-flight data therefore always has a free slot; no stall path exists on the ROM side.
- FIFO side:
  - output_V_write = buffer_not_empty & output_V_full_n (combinational on full_n).
  - output_V_din = buffer head.
  - A word leaves the buffer only on a cycle with write=1.
- Read/write overlap: occupancy update handles a simultaneous capture and pop in the same cycle, so 1 word/cycle is sustained with full_n held high.
- Address order: k_idx counts 0..NUM_KERN-1 and wraps to 0, incrementing pix_idx. Reads stop after pix_idx=PIX_PER_FRAME-1, k_idx=NUM_KERN-1. Total reads = total writes = NUM_KERN*PIX_PER_FRAME.
- FSM:
  - IDLE: busy=0. start -> RUN; counters cleared.
  - RUN: issue reads per the credit rule. After the final read -> DRAIN.
  - DRAIN: no reads. When the write counter reaches the total (last write accepted) -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: first write occurs 2 cycles after start when full_n=1 (cycle 1 read, cycle 2 captured/written). done pulses the cycle after the last accepted write.
- start while busy (RUN, DRAIN, DONE) is ignored. start in the same cycle done is high is also ignored.
- full_n low: write=0, din held stable. Reads stall once credits are exhausted and resume the cycle credits free up.
- NUM_KERN=1: address constant 0, one read per pixel.
- ap_rst_n asserted mid-frame: buffered and in-flight words are discarded. No write occurs until ap_rst_n is high and a new start is received.

Optional Feature:
- Macro BIAS_SEQ_STALL_CNT_EN.
- Defined: adds output port stall_cnt (32 bits). It counts cycles where busy=1 & buffer_not_empty & output_V_full_n=0. It clears on accepted start and on reset, saturates at 2^32-1, and holds its value after done.
- Undefined: no stall_cnt port or logic; behaviour otherwise identical.

Test Plan:
- NUM_KERN=4, PIX_PER_FRAME=2, ROM={0x0011,0x0022,0x0033,0x0044}, full_n=1, start at cycle 0 -> 8 writes on consecutive cycles 2..9, din 11,22,33,44,11,22,33,44; done pulse at cycle 10; busy high cycles 1..10.
- Same config with full_n toggling 1,0,0,1 repeating -> still exactly 8 writes in the same order. din stable while full_n=0, no address beyond 3, occupancy never >2.
- start re-pulsed at cycle 4 of a running frame -> ignored; write count stays 8, single done.
- ap_rst_n low at cycle 5 after 3 writes, released at cycle 7, no start -> no further writes, busy=0. Then start -> full 8-word frame from address 0.
- NUM_KERN=1, PIX_PER_FRAME=5, ROM={0x7FFF} -> 5 writes of 0x7FFF, address0 always 0.
- BIAS_SEQ_STALL_CNT_EN defined, full_n forced 0 for 6 cycles mid-frame -> stall_cnt=6 at done; cleared to 0 on next start.

Source files
------------

// File: rtl/bias_seq_ctrl_if.sv
// Bias ROM read port plus downstream ap_fifo write port for bias_seq_ctrl.
// The master side is the sequencer. The slave side is the ROM/FIFO environment.
interface bias_seq_ctrl_if #(
    parameter int ADDR_W     = 4,
    parameter int DATA_WIDTH = 16
);
    logic [ADDR_W-1:0]     bias_V_address0;
    logic                  bias_V_ce0;
    logic [DATA_WIDTH-1:0] bias_V_q0;
    logic [DATA_WIDTH-1:0] output_V_din;
    logic                  output_V_full_n;
    logic                  output_V_write;

    modport master (
        output bias_V_address0,
        output bias_V_ce0,
        input  bias_V_q0,
        output output_V_din,
        input  output_V_full_n,
        output output_V_write
    );

    modport slave (
        input  bias_V_address0,
        input  bias_V_ce0,
        output bias_V_q0,
        input  output_V_din,
        output output_V_full_n,
        input  output_V_write
    );
endinterface

// File: rtl/bias_seq_ctrl.sv
// Bias sequencer: sweeps the bias ROM PIX_PER_FRAME times into an ap_fifo with credit-based flow control.
// Optional stall_cnt output port and counter are enabled by defining BIAS_SEQ_STALL_CNT_EN.
module bias_seq_ctrl #(
    parameter int NUM_KERN      = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int PIX_PER_FRAME = 64,
    parameter int ADDR_W        = (NUM_KERN > 1) ? $clog2(NUM_KERN) : 1
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    bias_seq_ctrl_if.master   bus
`ifdef BIAS_SEQ_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int                PIX_W  = (PIX_PER_FRAME > 1) ? $clog2(PIX_PER_FRAME) : 1;
    localparam int                TOTAL  = NUM_KERN * PIX_PER_FRAME;
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NUM_KERN - 1);
    localparam logic [PIX_W-1:0]  P_LAST = PIX_W'(PIX_PER_FRAME - 1);
    localparam logic [31:0]       W_LAST = 32'(TOTAL - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]            k_idx;
    logic [PIX_W-1:0]             pix_idx;
    logic [31:0]                  wr_cnt;
    logic                         rd_en_p0;
    logic                         last_rd_p0;
    logic                         rd_vld_p1;
    logic signed [DATA_WIDTH-1:0] obuf_p1 [2];
    logic                         rd_ptr;
    logic                         wr_ptr;
    logic [1:0]                   occ;
    logic                         not_empty;
    logic                         wr_fire;
    logic                         bypass;
    logic                         push;
    logic                         pop;
    logic                         start_acc;

    // Stage p0: read issue under the two-credit rule (stored words + word in flight)
    always_comb begin
        start_acc  = (state == S_IDLE) && start;
        rd_en_p0   = (state == S_RUN) && ((occ + {1'b0, rd_vld_p1}) < 2'd2);
        last_rd_p0 = rd_en_p0 && (k_idx == K_LAST) && (pix_idx == P_LAST);
    end

    // Stage p1: the returning word counts as buffered. If the buffer is empty it can be written
    // straight through, which is the capture-and-pop-in-one-cycle case.
    always_comb begin
        not_empty = (occ != 2'd0) || rd_vld_p1;
        wr_fire   = not_empty && bus.output_V_full_n;
        bypass    = (occ == 2'd0) && wr_fire;
        push      = rd_vld_p1 && !bypass;
        pop       = wr_fire && !bypass;
    end

    always_comb begin
        bus.bias_V_ce0      = rd_en_p0;
        bus.bias_V_address0 = k_idx;
        bus.output_V_write  = wr_fire;
        if (occ != 2'd0)
            bus.output_V_din = obuf_p1[rd_ptr];
        else if (rd_vld_p1)
            bus.output_V_din = bus.bias_V_q0;
        else
            bus.output_V_din = '0;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_rd_p0) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (wr_fire && (wr_cnt == W_LAST)) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= S_IDLE;
            k_idx   <= '0;
            pix_idx <= '0;
            wr_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (start_acc) begin
                k_idx   <= '0;
                pix_idx <= '0;
                wr_cnt  <= '0;
            end else begin
                if (rd_en_p0) begin
                    if (k_idx == K_LAST) begin
                        k_idx   <= '0;
                        pix_idx <= pix_idx + PIX_W'(1);
                    end else begin
                        k_idx <= k_idx + ADDR_W'(1);
                    end
                end
                if (wr_fire) wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_vld_p1 <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occ       <= 2'd0;
            for (int i = 0; i < 2; i++) obuf_p1[i] <= '0;
        end else begin
            rd_vld_p1 <= rd_en_p0;
            if (push) begin
                obuf_p1[wr_ptr] <= bus.bias_V_q0;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef BIAS_SEQ_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            stall_cnt <= '0;
        else if (start_acc)
            stall_cnt <= '0;
        else if (busy && not_empty && !bus.output_V_full_n)
            stall_cnt <= sat_inc(stall_cnt);
    end
`endif

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Directed bench for bias_seq_ctrl: a 4x2 frame instance (A) and a 1x5 frame instance (B).
// Covers backpressure, ignored restarts, mid-frame reset and, with BIAS_SEQ_STALL_CNT_EN, stall_cnt.
module tb_bias_seq_ctrl;
    logic ap_clk;
    logic ap_rst_n;
    logic start_a, start_b;
    logic busy_a, done_a, busy_b, done_b;
`ifdef BIAS_SEQ_STALL_CNT_EN
    logic [31:0] stall_a, stall_b;
`endif

    bias_seq_ctrl_if #(.ADDR_W(2), .DATA_WIDTH(16)) if_a ();
    bias_seq_ctrl_if #(.ADDR_W(1), .DATA_WIDTH(16)) if_b ();

    bias_seq_ctrl #(.NUM_KERN(4), .DATA_WIDTH(16), .PIX_PER_FRAME(2)) u_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start_a),
        .busy(busy_a), .done(done_a), .bus(if_a)
`ifdef BIAS_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_a)
`endif
    );

    bias_seq_ctrl #(.NUM_KERN(1), .DATA_WIDTH(16), .PIX_PER_FRAME(5)) u_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start_b),
        .busy(busy_b), .done(done_b), .bus(if_b)
`ifdef BIAS_SEQ_STALL_CNT_EN
        , .stall_cnt(stall_b)
`endif
    );

    logic [15:0] rom_a [4];
    assign rom_a[0] = 16'h0011;
    assign rom_a[1] = 16'h0022;
    assign rom_a[2] = 16'h0033;
    assign rom_a[3] = 16'h0044;

    always @(posedge ap_clk) if (if_a.bias_V_ce0) if_a.bias_V_q0 <= rom_a[if_a.bias_V_address0];
    always @(posedge ap_clk) if (if_b.bias_V_ce0) if_b.bias_V_q0 <= 16'h7FFF;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] wa_data[$];
    int          wa_cyc[$];
    int          da_cyc[$];
    logic [15:0] wb_data[$];
    int          db_cnt;
    int          busy_first, busy_last;
    int          max_addr, first_addr;
    int          occ_bad, din_bad, b_addr_bad;
    logic        prev_hold;
    logic [15:0] prev_din;
    logic [15:0] exp_a [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One stimulus window of ncyc cycles. Cycle k starts at a rising edge. Inputs change 1ns later,
    // and outputs are logged on the falling edge. full_n mode: 0 = always high,
    // 1 = 1,0,0,1 repeating, 2 = low for cycles 4..9.
    task automatic run(input int ncyc, input int sa, input int sa2, input int sb,
                       input int mode, input int rlo, input int rhi);
        wa_data.delete(); wa_cyc.delete(); da_cyc.delete(); wb_data.delete();
        db_cnt = 0; busy_first = -1; busy_last = -1; max_addr = 0; first_addr = -1;
        occ_bad = 0; din_bad = 0; b_addr_bad = 0; prev_hold = 1'b0; prev_din = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge ap_clk);
            #1;
            start_a  = (k == sa) || (k == sa2);
            start_b  = (k == sb);
            ap_rst_n = !((k >= rlo) && (k < rhi));
            case (mode)
                1:       if_a.output_V_full_n = ((k % 4) == 0) || ((k % 4) == 3);
                2:       if_a.output_V_full_n = !((k >= 4) && (k < 10));
                default: if_a.output_V_full_n = 1'b1;
            endcase
            @(negedge ap_clk);
            if (if_a.output_V_write) begin
                wa_data.push_back(if_a.output_V_din);
                wa_cyc.push_back(k);
            end
            if (done_a) da_cyc.push_back(k);
            if (busy_a) begin
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (if_a.bias_V_ce0) begin
                if (first_addr < 0) first_addr = int'(if_a.bias_V_address0);
                if (int'(if_a.bias_V_address0) > max_addr) max_addr = int'(if_a.bias_V_address0);
            end
            if ((int'(u_a.occ) + int'(u_a.rd_vld_p1)) > 2) occ_bad++;
            if (prev_hold && (if_a.output_V_din !== prev_din)) din_bad++;
            prev_hold = busy_a && u_a.not_empty && !if_a.output_V_full_n;
            prev_din  = if_a.output_V_din;
            if (if_b.output_V_write) wb_data.push_back(if_b.output_V_din);
            if (if_b.bias_V_ce0 && (if_b.bias_V_address0 != 1'b0)) b_addr_bad++;
            if (done_b) db_cnt++;
        end
    endtask

    task automatic chk_order(input string tag);
        chk({tag, "_count"}, 32'(wa_data.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_din%0d", tag, i),
                (i < wa_data.size()) ? 32'(wa_data[i]) : 32'hDEAD, 32'(exp_a[i]));
    endtask

    initial begin
        exp_a = '{16'h0011, 16'h0022, 16'h0033, 16'h0044,
                  16'h0011, 16'h0022, 16'h0033, 16'h0044};
        ap_rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        if_a.output_V_full_n = 1'b1;
        if_b.output_V_full_n = 1'b1;

        // Reset state
        @(negedge ap_clk);
        chk("rst_busy",  32'(busy_a), 32'd0);
        chk("rst_done",  32'(done_a), 32'd0);
        chk("rst_ce0",   32'(if_a.bias_V_ce0), 32'd0);
        chk("rst_addr",  32'(if_a.bias_V_address0), 32'd0);
        chk("rst_write", 32'(if_a.output_V_write), 32'd0);
        chk("rst_din",   32'(if_a.output_V_din), 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        run(3, -1, -1, -1, 0, -1, -1);

        // Nominal frame on A and the NUM_KERN=1 frame on B, both started at cycle 0
        run(16, 0, -1, 0, 0, -1, -1);
        chk_order("nom");
        for (int i = 0; i < 8; i++)
            chk($sformatf("nom_cyc%0d", i), (i < wa_cyc.size()) ? 32'(wa_cyc[i]) : 32'hDEAD, 32'(i + 2));
        chk("nom_done_cnt", 32'(da_cyc.size()), 32'd1);
        chk("nom_done_cyc", (da_cyc.size() > 0) ? 32'(da_cyc[0]) : 32'hDEAD, 32'd10);
        chk("nom_busy_first", 32'(busy_first), 32'd1);
        chk("nom_busy_last",  32'(busy_last), 32'd10);
        chk("nom_first_addr", 32'(first_addr), 32'd0);
        chk("b_count", 32'(wb_data.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("b_din%0d", i), (i < wb_data.size()) ? 32'(wb_data[i]) : 32'hDEAD, 32'h7FFF);
        chk("b_addr_nonzero", 32'(b_addr_bad), 32'd0);
        chk("b_done_cnt", 32'(db_cnt), 32'd1);

        // Backpressure: full_n 1,0,0,1 repeating
        run(40, 0, -1, -1, 1, -1, -1);
        chk_order("bp");
        chk("bp_max_addr", 32'(max_addr), 32'd3);
        chk("bp_occ_over2", 32'(occ_bad), 32'd0);
        chk("bp_din_moved", 32'(din_bad), 32'd0);
        chk("bp_done_cnt", 32'(da_cyc.size()), 32'd1);
        chk("bp_busy_end", 32'(busy_a), 32'd0);

        // Second start at cycle 4 of a running frame is ignored
        run(16, 0, 4, -1, 0, -1, -1);
        chk_order("restart");
        chk("restart_done_cnt", 32'(da_cyc.size()), 32'd1);

        // Reset asserted at cycle 5 after three writes, released at 7, no new start
        run(20, 0, -1, -1, 0, 5, 7);
        chk("rst_mid_writes", 32'(wa_data.size()), 32'd3);
        chk("rst_mid_busy", 32'(busy_a), 32'd0);
        chk("rst_mid_done_cnt", 32'(da_cyc.size()), 32'd0);
        run(16, 0, -1, -1, 0, -1, -1);
        chk_order("after_rst");
        chk("after_rst_first_addr", 32'(first_addr), 32'd0);

`ifdef BIAS_SEQ_STALL_CNT_EN
        // full_n held low for cycles 4..9 while words are pending
        run(24, 0, -1, -1, 2, -1, -1);
        chk_order("stall");
        chk("stall_cnt_at_done", stall_a, 32'd6);
        chk("stall_din_moved", 32'(din_bad), 32'd0);
        run(2, 0, -1, -1, 0, -1, -1);
        chk("stall_cnt_cleared", stall_a, 32'd0);
        run(16, -1, -1, -1, 0, -1, -1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
